// File: rtl/frame_buf_scheduler_pkg.sv
// Shared types for the camera ping-pong buffer path.
// Buffer/reader state encodings used by scheduler, writer and reader.
package frame_buf_scheduler_pkg;

   typedef enum logic [1:0] {
      BUF_FREE    = 2'd0,
      BUF_WRITING = 2'd1,
      BUF_FULL    = 2'd2,
      BUF_READING = 2'd3
   } buf_state_e;

   typedef enum logic [1:0] {
      RD_IDLE   = 2'd0,
      RD_START  = 2'd1,
      RD_ACTIVE = 2'd2
   } rd_state_e;

   function automatic logic [1:0] full_vec(
      input buf_state_e b0,
      input buf_state_e b1
   );
      return {b1 == BUF_FULL, b0 == BUF_FULL};
   endfunction

   function automatic logic [1:0] free_vec(
      input buf_state_e b0,
      input buf_state_e b1
   );
      return {b1 == BUF_FREE, b0 == BUF_FREE};
   endfunction

endpackage

// File: rtl/frame_buf_scheduler.sv
// Ping-pong scheduler for the two camera input buffers.
// Allocates write buffers, hands FULL buffers to the reader, counts drops.
module frame_buf_scheduler
   import frame_buf_scheduler_pkg::*;
#(
   parameter bit OVERWRITE = 1'b1,
   parameter int DROP_W    = 16
) (
   input  logic              iClk,
   input  logic              wRsn,
   input  logic              iWrFrmStart,
   input  logic              iWrFrmDone,
   input  logic              iRdReady,
   input  logic              iRdFrmDone,
   output logic              oWrBufSel,
   output logic              oWrAllow,
   output logic              oRdBufSel,
   output logic              oRdStart,
   output logic              oRdBusy,
   output logic [1:0]        oBufFull,
   output logic [DROP_W-1:0] oDropCnt
);

   buf_state_e        st_q [2];
   buf_state_e        st_d [2];
   rd_state_e         rd_q, rd_d;
   logic              wr_sel_q, wr_sel_d;
   logic              wr_allow_q, wr_allow_d;
   logic              rd_sel_q, rd_sel_d;
   logic              age_q, age_d;
   logic              pref_q, pref_d;
   logic [DROP_W-1:0] drop_q, drop_d;

   logic [1:0] full_q, fullw, freew, fullf;
   logic       pick, alloc, do_alloc, drop_inc, older;

   assign full_q = full_vec(st_q[0], st_q[1]);
   // Both FULL with no prior pair means the one just completed is newer.
   assign older  = (&full_q) ? age_q : ~wr_sel_q;

   always_comb begin
      st_d       = st_q;
      rd_d       = rd_q;
      wr_sel_d   = wr_sel_q;
      wr_allow_d = wr_allow_q;
      rd_sel_d   = rd_sel_q;
      age_d      = age_q;
      pref_d     = pref_q;
      drop_inc   = 1'b0;
      pick       = 1'b0;
      alloc      = 1'b0;
      do_alloc   = 1'b0;
      freew      = '0;
      fullw      = '0;
      fullf      = '0;

      if (rd_q == RD_ACTIVE && iRdFrmDone) begin
         st_d[rd_sel_q] = BUF_FREE;
         rd_d           = RD_IDLE;
      end
      if (rd_q == RD_START) begin
         rd_d = RD_ACTIVE;
      end

      if (iWrFrmDone && wr_allow_q) begin
         st_d[wr_sel_q] = BUF_FULL;
         wr_allow_d     = 1'b0;
      end

      if (rd_q == RD_IDLE && iRdReady && |full_q) begin
         pick        = (&full_q) ? age_q : full_q[1];
         rd_sel_d    = pick;
         st_d[pick]  = BUF_READING;
         rd_d        = RD_START;
      end

      if (iWrFrmStart) begin
         for (int i = 0; i < 2; i++) begin
            if (st_d[i] == BUF_WRITING) begin
               st_d[i]  = BUF_FREE;
               drop_inc = 1'b1;
            end
         end
         freew = free_vec(st_d[0], st_d[1]);
         fullw = full_vec(st_d[0], st_d[1]);
         if (&freew) begin
            do_alloc = 1'b1;
            alloc    = pref_q;
         end else if (|freew) begin
            do_alloc = 1'b1;
            alloc    = freew[1];
         end else if (OVERWRITE && |fullw) begin
            do_alloc = 1'b1;
            alloc    = (&fullw) ? older : fullw[1];
            drop_inc = 1'b1;
         end else begin
            drop_inc = 1'b1;
         end
         if (do_alloc) begin
            st_d[alloc] = BUF_WRITING;
            wr_sel_d    = alloc;
            wr_allow_d  = 1'b1;
            pref_d      = ~alloc;
         end else begin
            wr_allow_d  = 1'b0;
         end
      end

      fullf = full_vec(st_d[0], st_d[1]);
      if (&fullf) begin
         age_d = older;
      end else if (|fullf) begin
         age_d = fullf[1];
      end
   end

   assign drop_d = (drop_inc && !(&drop_q)) ?
                   drop_q + 1'b1 : drop_q;

   always_ff @(posedge iClk or negedge wRsn) begin
      if (!wRsn) begin
         st_q[0]    <= BUF_FREE;
         st_q[1]    <= BUF_FREE;
         rd_q       <= RD_IDLE;
         wr_sel_q   <= 1'b0;
         wr_allow_q <= 1'b0;
         rd_sel_q   <= 1'b0;
         age_q      <= 1'b0;
         pref_q     <= 1'b0;
         drop_q     <= '0;
      end else begin
         st_q       <= st_d;
         rd_q       <= rd_d;
         wr_sel_q   <= wr_sel_d;
         wr_allow_q <= wr_allow_d;
         rd_sel_q   <= rd_sel_d;
         age_q      <= age_d;
         pref_q     <= pref_d;
         drop_q     <= drop_d;
      end
   end

   assign oWrBufSel = wr_sel_q;
   assign oWrAllow  = wr_allow_q;
   assign oRdBufSel = rd_sel_q;
   assign oRdStart  = (rd_q == RD_START);
   assign oRdBusy   = (rd_q != RD_IDLE);
   assign oBufFull  = full_q;
   assign oDropCnt  = drop_q;

endmodule

// File: tb/tb_frame_buf_scheduler.sv
// Bench for frame_buf_scheduler: OVERWRITE=1 and OVERWRITE=0 side by side.
// Model keeps FULL buffers as an oldest-first list.
module tb_frame_buf_scheduler;

   localparam int FR  = 0;
   localparam int WR  = 1;
   localparam int FL  = 2;
   localparam int RDG = 3;
   localparam int DMAX = 15;

   logic iClk, wRsn;
   logic s_start, s_done, s_rdy, s_rfd;

   logic       ws [2];
   logic       wa [2];
   logic       rs [2];
   logic       st [2];
   logic       rb [2];
   logic [1:0] bf [2];
   logic [3:0] dc [2];

   int checks = 0;
   int errors = 0;

   int mb  [2][2];
   int fq  [2][2];
   int fn  [2];
   int mws [2];
   int mal [2];
   int mrs [2];
   int mph [2];
   int mdr [2];
   int mpr [2];

   frame_buf_scheduler #(.OVERWRITE(1'b1), .DROP_W(4)) u_ow (
      .iClk(iClk), .wRsn(wRsn),
      .iWrFrmStart(s_start), .iWrFrmDone(s_done),
      .iRdReady(s_rdy), .iRdFrmDone(s_rfd),
      .oWrBufSel(ws[0]), .oWrAllow(wa[0]),
      .oRdBufSel(rs[0]), .oRdStart(st[0]),
      .oRdBusy(rb[0]), .oBufFull(bf[0]),
      .oDropCnt(dc[0])
   );

   frame_buf_scheduler #(.OVERWRITE(1'b0), .DROP_W(4)) u_dr (
      .iClk(iClk), .wRsn(wRsn),
      .iWrFrmStart(s_start), .iWrFrmDone(s_done),
      .iRdReady(s_rdy), .iRdFrmDone(s_rfd),
      .oWrBufSel(ws[1]), .oWrAllow(wa[1]),
      .oRdBufSel(rs[1]), .oRdStart(st[1]),
      .oRdBusy(rb[1]), .oBufFull(bf[1]),
      .oDropCnt(dc[1])
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic chk(input string nm, input int act,
                      input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
      end
   endtask

   task automatic mreset();
      for (int k = 0; k < 2; k++) begin
         mb[k][0] = FR; mb[k][1] = FR;
         fn[k] = 0; mws[k] = 0; mal[k] = 0;
         mrs[k] = 0; mph[k] = 0; mdr[k] = 0;
         mpr[k] = 0;
      end
   endtask

   task automatic bump(input int k);
      if (mdr[k] < DMAX) mdr[k]++;
   endtask

   task automatic pop(input int k);
      fq[k][0] = fq[k][1];
      fn[k]--;
   endtask

   task automatic mstep(input int k, input bit ow);
      int ofn;
      int x;
      bit idle;
      ofn  = fn[k];
      idle = (mph[k] == 0);
      x    = -1;
      if (mph[k] == 2 && s_rfd) begin
         mb[k][mrs[k]] = FR;
         mph[k] = 0;
      end else if (mph[k] == 1) begin
         mph[k] = 2;
      end
      if (s_done && mal[k] != 0) begin
         mb[k][mws[k]] = FL;
         fq[k][fn[k]] = mws[k];
         fn[k]++;
         mal[k] = 0;
      end
      if (idle && s_rdy && ofn > 0) begin
         mrs[k] = fq[k][0];
         mb[k][mrs[k]] = RDG;
         pop(k);
         mph[k] = 1;
      end
      if (s_start) begin
         for (int i = 0; i < 2; i++) begin
            if (mb[k][i] == WR) begin
               mb[k][i] = FR;
               bump(k);
            end
         end
         if (mb[k][0] == FR && mb[k][1] == FR) x = mpr[k];
         else if (mb[k][0] == FR) x = 0;
         else if (mb[k][1] == FR) x = 1;
         else if (ow && fn[k] > 0) begin
            x = fq[k][0];
            pop(k);
            bump(k);
         end else bump(k);
         if (x >= 0) begin
            mb[k][x] = WR;
            mws[k] = x;
            mal[k] = 1;
            mpr[k] = 1 - x;
         end else begin
            mal[k] = 0;
         end
      end
   endtask

   always @(posedge iClk or negedge wRsn) begin
      if (!wRsn) mreset();
      else begin
         mstep(0, 1'b1);
         mstep(1, 1'b0);
      end
   end

   always @(negedge iClk) begin
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("i%0d wrsel", k), ws[k], mws[k]);
         chk($sformatf("i%0d wrallow", k), wa[k], mal[k]);
         chk($sformatf("i%0d rdsel", k), rs[k], mrs[k]);
         chk($sformatf("i%0d rdstart", k), st[k],
             int'(mph[k] == 1));
         chk($sformatf("i%0d rdbusy", k), rb[k],
             int'(mph[k] != 0));
         chk($sformatf("i%0d buffull", k), bf[k],
             2 * int'(mb[k][1] == FL) + int'(mb[k][0] == FL));
         chk($sformatf("i%0d dropcnt", k), dc[k], mdr[k]);
      end
   end

   task automatic cyc(input bit s, input bit d,
                      input bit r, input bit f);
      s_start = s; s_done = d; s_rdy = r; s_rfd = f;
      @(posedge iClk);
      #2;
      s_start = 0; s_done = 0; s_rdy = 0; s_rfd = 0;
   endtask

   task automatic hard_reset();
      wRsn = 1'b0;
      repeat (2) @(posedge iClk);
      #2;
      wRsn = 1'b1;
   endtask

   task automatic chk_rst(input string tag);
      for (int k = 0; k < 2; k++) begin
         chk({tag, " wrsel"}, ws[k], 0);
         chk({tag, " wrallow"}, wa[k], 0);
         chk({tag, " rdsel"}, rs[k], 0);
         chk({tag, " rdstart"}, st[k], 0);
         chk({tag, " rdbusy"}, rb[k], 0);
         chk({tag, " buffull"}, bf[k], 0);
         chk({tag, " dropcnt"}, dc[k], 0);
      end
   endtask

   initial begin
      s_start = 0; s_done = 0; s_rdy = 0; s_rfd = 0;
      wRsn = 1'b0;
      repeat (2) @(posedge iClk);
      #2;
      chk_rst("reset");
      wRsn = 1'b1;

      // single frame through both sides
      cyc(1, 0, 0, 0);
      chk("s1 wrsel", ws[0], 0);
      chk("s1 wrallow", wa[0], 1);
      cyc(0, 1, 1, 0);
      chk("s1 full", bf[0], 1);
      chk("s1 nostart", st[0], 0);
      cyc(0, 0, 1, 0);
      chk("s1 rdstart", st[0], 1);
      chk("s1 rdsel", rs[0], 0);
      cyc(0, 0, 0, 0);
      chk("s1 pulse", st[0], 0);
      chk("s1 busy", rb[0], 1);
      cyc(0, 0, 0, 1);
      chk("s1 free", bf[0], 0);
      chk("s1 idle", rb[0], 0);

      // two frames, oldest read first
      hard_reset();
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(1, 0, 0, 0);
      chk("s2 wrsel", ws[0], 1);
      cyc(0, 1, 0, 0);
      chk("s2 both", bf[0], 3);
      cyc(0, 0, 1, 0);
      chk("s2 first", rs[0], 0);
      chk("s2 left", bf[0], 2);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 1);
      cyc(0, 0, 1, 0);
      chk("s2 second", rs[0], 1);
      chk("s2 start", st[0], 1);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 1);

      // overwrite vs drop, then async reset in RD_ACTIVE
      hard_reset();
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(1, 0, 1, 0);
      cyc(0, 1, 0, 0);
      cyc(1, 0, 0, 0);
      chk("s3 ow wrsel", ws[0], 1);
      chk("s3 ow allow", wa[0], 1);
      chk("s3 ow drop", dc[0], 1);
      chk("s3 ow full", bf[0], 0);
      chk("s3 dr allow", wa[1], 0);
      chk("s3 dr drop", dc[1], 1);
      chk("s3 dr full", bf[1], 2);
      chk("s3 dr busy", rb[1], 1);
      #1;
      wRsn = 1'b0;
      #1;
      chk_rst("async");
      @(posedge iClk);
      #2;
      wRsn = 1'b1;

      // aborted frame
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      chk("s4 wrsel", ws[0], 1);
      chk("s4 allow", wa[0], 1);
      chk("s4 drop", dc[0], 1);
      chk("s4 full", bf[0], 0);

      // read done and frame start together
      cyc(0, 1, 0, 0);
      cyc(1, 0, 1, 0);
      cyc(0, 1, 0, 0);
      cyc(1, 0, 0, 1);
      chk("s5 wrsel", ws[0], 1);
      chk("s5 allow", wa[0], 1);
      chk("s5 drop", dc[0], 1);
      chk("s5 full", bf[0], 1);
      chk("s5 idle", rb[0], 0);

      // frame done and frame start together, both full
      cyc(1, 1, 0, 0);
      chk("s6 ow wrsel", ws[0], 0);
      chk("s6 ow drop", dc[0], 2);
      chk("s6 ow full", bf[0], 2);
      chk("s6 dr allow", wa[1], 0);
      chk("s6 dr full", bf[1], 3);
      cyc(0, 0, 1, 0);
      chk("s6 ow rdsel", rs[0], 1);
      chk("s6 dr rdsel", rs[1], 0);

      // drop counter saturation
      for (int n = 0; n < 20; n++) cyc(1, 0, 0, 0);
      chk("s7 ow sat", dc[0], DMAX);
      chk("s7 dr sat", dc[1], DMAX);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
